// File: rtl/bus_irq_dispatch_pkg.sv
// Shared definitions for the interrupt dispatcher.
// Holds the FSM state encoding, the bus width constants shared with the bus slave blocks,
// and a helper that sizes the shared wait/settle counter.
package bus_irq_dispatch_pkg;

    localparam int unsigned BusAddrWidth = 32;
    localparam int unsigned BusDataWidth = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StDisp,
        StWr,
        StGuard
    } state_e;

    // Width of a counter that must reach max(a, b); never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_irq_dispatch_prio_enc.sv
// irq_prio_enc: combinational find-first-set with a start index.
// The search begins at start_i and wraps modulo Width, so start_i = 0 gives plain
// lowest-set-bit priority.
// Ports:
//   req_i    request vector
//   start_i  first index to examine (must be < Width)
//   found_o  at least one request bit is set
//   idx_o    index of the first set bit at or after start_i (wrapping)
module irq_prio_enc #(
    parameter int unsigned Width = 32,
    parameter int unsigned IdW   = 5
) (
    input  logic [Width-1:0] req_i,
    input  logic [IdW-1:0]   start_i,
    output logic             found_o,
    output logic [IdW-1:0]   idx_o
);

    logic [IdW:0] pos;

    // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = Width - 1; k >= 0; k--) begin
            pos = {1'b0, start_i} + (IdW + 1)'(k);
            if (pos >= (IdW + 1)'(Width)) begin
                pos = pos - (IdW + 1)'(Width);
            end
            if (req_i[pos[IdW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IdW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_irq_dispatch.sv
// bus_irq_dispatch: bus-master servicing end of one interrupt register.
// On irq it reads the register, offers each enabled pending bit as an ID over a
// valid/ready handshake, then writes the handled bits back so they toggle to 0.
// Build option: define IRQ_DISPATCH_RR_EN for round-robin ID selection; otherwise
// the lowest pending bit is always offered first.
// Ports:
//   bus_clk_i, bus_reset_i          clock, asynchronous active-high reset
//   irq_i, mask_i                   interrupt request and per-bit service enable
//   mst_addr_o/re_o/we_o/wr_data_o  bus master request
//   mst_rd_data_i/rd_ack_i/wr_ack_i bus master response (acks may be combinational)
//   vec_valid_o/vec_id_o/vec_ready_i interrupt ID handshake
//   busy_o, err_o                   FSM not idle; sticky bus timeout
module bus_irq_dispatch
    import bus_irq_dispatch_pkg::*;
#(
    parameter int unsigned ADDR           = 0,
    parameter int unsigned OFFSET         = 0,
    parameter int unsigned DATAWIDTH      = 32,
    parameter int unsigned BUS_ADDR_WIDTH = BusAddrWidth,
    parameter int unsigned BUS_DATA_WIDTH = BusDataWidth,
    parameter int unsigned IDW            = 5,
    parameter int unsigned TIMEOUT        = 255,
    parameter int unsigned GUARD          = 3
) (
    input  logic                      bus_clk_i,
    input  logic                      bus_reset_i,
    input  logic                      irq_i,
    input  logic [DATAWIDTH-1:0]      mask_i,
    output logic [BUS_ADDR_WIDTH-1:0] mst_addr_o,
    output logic                      mst_re_o,
    output logic                      mst_we_o,
    output logic [BUS_DATA_WIDTH-1:0] mst_wr_data_o,
    input  logic [BUS_DATA_WIDTH-1:0] mst_rd_data_i,
    input  logic                      mst_rd_ack_i,
    input  logic                      mst_wr_ack_i,
    output logic                      vec_valid_o,
    output logic [IDW-1:0]            vec_id_o,
    input  logic                      vec_ready_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned CntW = cnt_width(TIMEOUT, GUARD);

    state_e                    state_q, state_d;
    logic [DATAWIDTH-1:0]      pending_q, pending_d;
    logic [DATAWIDTH-1:0]      handled_q, handled_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      vec_valid_q, vec_valid_d;
    logic [IDW-1:0]            vec_id_q, vec_id_d;
    logic [IDW-1:0]            start_idx;
    logic                      enc_found;
    logic [IDW-1:0]            enc_idx;
    logic                      fire;
    logic [DATAWIDTH-1:0]      sel_bit;
    logic [DATAWIDTH-1:0]      rd_bits;
    logic [BUS_DATA_WIDTH-1:0] rd_shifted;

    assign rd_shifted = mst_rd_data_i >> OFFSET;
    assign rd_bits    = rd_shifted[DATAWIDTH-1:0] & mask_i;
    assign fire       = vec_valid_q & vec_ready_i;
    assign sel_bit    = DATAWIDTH'(1) << vec_id_q;

    generate
        if (BUS_DATA_WIDTH > DATAWIDTH) begin : g_rd_hi
            logic unused_rd_hi;
            assign unused_rd_hi = ^rd_shifted[BUS_DATA_WIDTH-1:DATAWIDTH];
        end
    endgenerate

`ifdef IRQ_DISPATCH_RR_EN
    logic [IDW-1:0] last_q, last_d;

    assign last_d    = fire ? vec_id_q : last_q;
    assign start_idx = (last_d == IDW'(DATAWIDTH - 1)) ? '0 : last_d + IDW'(1);

    always_ff @(posedge bus_clk_i or posedge bus_reset_i) begin
        if (bus_reset_i) begin
            last_q <= IDW'(DATAWIDTH - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign start_idx = '0;
`endif

    // Searching the post-accept pending set lets the next ID appear the cycle after an accept.
    irq_prio_enc #(
        .Width (DATAWIDTH),
        .IdW   (IDW)
    ) u_prio_enc (
        .req_i   (pending_d),
        .start_i (start_idx),
        .found_o (enc_found),
        .idx_o   (enc_idx)
    );

    // State register and datapath registers.
    always_ff @(posedge bus_clk_i or posedge bus_reset_i) begin
        if (bus_reset_i) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            handled_q   <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            handled_q   <= handled_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            vec_valid_q <= vec_valid_d;
            vec_id_q    <= vec_id_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        handled_d = handled_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (irq_i) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                if (mst_rd_ack_i) begin
                    pending_d = rd_bits;
                    handled_d = '0;
                    state_d   = (|rd_bits) ? StDisp : StGuard;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StGuard;
                end
            end
            StDisp: begin
                if (fire) begin
                    pending_d = pending_q & ~sel_bit;
                    handled_d = handled_q | sel_bit;
                    if (pending_d == '0) begin
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                if (mst_wr_ack_i) begin
                    state_d = StGuard;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StGuard;
                end
            end
            StGuard: begin
                if (cnt_q == CntW'(GUARD - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // One counter serves both the ack timeout and the guard interval.
        if (state_d != state_q || state_q == StIdle || state_q == StDisp) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        vec_valid_d = (state_q == StDisp) && enc_found;
        vec_id_d    = vec_valid_d ? enc_idx : '0;
    end

    // Outputs.
    always_comb begin
        mst_re_o      = 1'b0;
        mst_we_o      = 1'b0;
        mst_addr_o    = '0;
        mst_wr_data_o = '0;
        unique case (state_q)
            StRd: begin
                mst_re_o   = 1'b1;
                mst_addr_o = BUS_ADDR_WIDTH'(ADDR);
            end
            StWr: begin
                mst_we_o      = 1'b1;
                mst_addr_o    = BUS_ADDR_WIDTH'(ADDR);
                mst_wr_data_o = BUS_DATA_WIDTH'(handled_q) << OFFSET;
            end
            default: ;
        endcase
        busy_o      = (state_q != StIdle);
        err_o       = err_q;
        vec_valid_o = vec_valid_q;
        vec_id_o    = vec_id_q;
    end

endmodule
